commit_trace_gen: RTL and testbench

COMMIT_TRACE_GEN -- requirements
Module: commit_trace_gen

---
 rtl/commit_trace_gen.sv | 130 +++++++++++++
 tb/tb_commit_trace_gen.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/commit_trace_gen.sv
`default_nettype none
// ============================================================================
// Module      : commit_trace_gen
// Description : Shadow EX/MEM/WB pipeline that turns decode-stage records into
//               an in-order commit trace with instruction and cycle counters.
// Revision    : 1.0 - initial release
// ============================================================================
module commit_trace_gen #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [15:0]      id_pc,
    input  logic [15:0]      id_inst,
    input  logic             id_reg_write,
    input  logic [2:0]       id_write_reg,
    input  logic             id_mem_read,
    input  logic             id_mem_write,
    input  logic             id_halt,
    input  logic             stall,
    input  logic             flush,
    input  logic             mem_stall,
    input  logic [15:0]      ex_alu_out,
    input  logic [15:0]      ex_store_data,
    input  logic [15:0]      wb_write_data,
    output logic             cm_valid,
    output logic [15:0]      cm_pc,
    output logic [15:0]      cm_inst,
    output logic             cm_reg_write,
    output logic [2:0]       cm_write_reg,
    output logic [15:0]      cm_write_data,
    output logic             cm_mem_read,
    output logic             cm_mem_write,
    output logic [15:0]      cm_mem_addr,
    output logic [15:0]      cm_mem_data,
    output logic             cm_halt,
    output logic [CNT_W-1:0] inst_count,
    output logic [CNT_W-1:0] cycle_count,
    output logic             halted
);

    typedef struct packed {
        logic        valid;
        logic [15:0] pc;
        logic [15:0] inst;
        logic        regWrite;
        logic [2:0]  writeReg;
        logic        memRead;
        logic        memWrite;
        logic        halt;
    } rec_t;

    typedef struct packed {
        rec_t        rec;
        logic [15:0] memAddr;
        logic [15:0] memData;
    } memRec_t;

    localparam logic [CNT_W-1:0] c_one = CNT_W'(1);

    rec_t             r_ex;
    memRec_t          r_mem;
    memRec_t          r_wb;
    logic             r_halted;
    logic [CNT_W-1:0] r_instCount;
    logic [CNT_W-1:0] r_cycleCount;

    rec_t             w_idRec;
    logic             w_cmValid;

    always_comb begin
        w_idRec          = '0;
        w_idRec.valid    = id_valid & ~stall & ~flush & ~r_halted;
        w_idRec.pc       = id_pc;
        w_idRec.inst     = id_inst;
        w_idRec.regWrite = id_reg_write;
        w_idRec.writeReg = id_write_reg;
        w_idRec.memRead  = id_mem_read;
        w_idRec.memWrite = id_mem_write;
        w_idRec.halt     = id_halt;
    end

    // The WB record is only reported on a non-frozen cycle, so a frozen WB
    // record commits exactly once, on the cycle the freeze lifts.
    assign w_cmValid = r_wb.rec.valid & ~mem_stall & ~r_halted;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ex         <= '0;
            r_mem        <= '0;
            r_wb         <= '0;
            r_halted     <= 1'b0;
            r_instCount  <= '0;
            r_cycleCount <= '0;
        end else begin
            if (!mem_stall) begin
                r_ex  <= w_idRec;
                r_mem <= '{rec: r_ex, memAddr: ex_alu_out, memData: ex_store_data};
                r_wb  <= r_mem;
            end
            if (w_cmValid) begin
                r_instCount <= r_instCount + c_one;
                if (r_wb.rec.halt) begin
                    r_halted <= 1'b1;
                end
            end
            if (!r_halted) begin
                r_cycleCount <= r_cycleCount + c_one;
            end
        end
    end

    assign cm_valid      = w_cmValid;
    assign cm_pc         = w_cmValid ? r_wb.rec.pc       : 16'h0000;
    assign cm_inst       = w_cmValid ? r_wb.rec.inst     : 16'h0000;
    assign cm_reg_write  = w_cmValid & r_wb.rec.regWrite;
    assign cm_write_reg  = w_cmValid ? r_wb.rec.writeReg : 3'b000;
    assign cm_write_data = w_cmValid ? wb_write_data     : 16'h0000;
    assign cm_mem_read   = w_cmValid & r_wb.rec.memRead;
    assign cm_mem_write  = w_cmValid & r_wb.rec.memWrite;
    assign cm_mem_addr   = w_cmValid ? r_wb.memAddr      : 16'h0000;
    assign cm_mem_data   = w_cmValid ? r_wb.memData      : 16'h0000;
    assign cm_halt       = w_cmValid & r_wb.rec.halt;
    assign inst_count    = r_instCount;
    assign cycle_count   = r_cycleCount;
    assign halted        = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_commit_trace_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_commit_trace_gen
// Description : Directed plus randomized bench for commit_trace_gen against a
//               latency-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_commit_trace_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_reg_write, id_mem_read, id_mem_write, id_halt;
    logic [15:0] id_pc, id_inst;
    logic [2:0]  id_write_reg;
    logic        stall, flush, mem_stall;
    logic [15:0] ex_alu_out, ex_store_data, wb_write_data;
    logic        cm_valid, cm_reg_write, cm_mem_read, cm_mem_write, cm_halt;
    logic [15:0] cm_pc, cm_inst, cm_write_data, cm_mem_addr, cm_mem_data;
    logic [2:0]  cm_write_reg;
    logic [31:0] inst_count, cycle_count;
    logic        halted;

    always #5 clk = ~clk;

    commit_trace_gen #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst),
        .id_reg_write(id_reg_write), .id_write_reg(id_write_reg),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_halt(id_halt),
        .stall(stall), .flush(flush), .mem_stall(mem_stall),
        .ex_alu_out(ex_alu_out), .ex_store_data(ex_store_data),
        .wb_write_data(wb_write_data),
        .cm_valid(cm_valid), .cm_pc(cm_pc), .cm_inst(cm_inst),
        .cm_reg_write(cm_reg_write), .cm_write_reg(cm_write_reg),
        .cm_write_data(cm_write_data), .cm_mem_read(cm_mem_read),
        .cm_mem_write(cm_mem_write), .cm_mem_addr(cm_mem_addr),
        .cm_mem_data(cm_mem_data), .cm_halt(cm_halt),
        .inst_count(inst_count), .cycle_count(cycle_count), .halted(halted)
    );

    // Each accepted record needs two more unfrozen edges to be commit-eligible.
    typedef struct {
        logic [15:0] pc, inst, addr, data;
        logic        rw, mr, mw, hlt;
        logic [2:0]  wr;
        int          age;
    } mrec_t;

    mrec_t       q[$];
    int unsigned mInst, mCycle;
    bit          mHalted;
    int          nCmp = 0;
    int          nFail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int eligibleIdx();
        for (int i = 0; i < q.size(); i++)
            if (q[i].age == 2) return i;
        return -1;
    endfunction

    task automatic checkOutputs();
        int  k;
        bit  v;
        mrec_t r;
        k = eligibleIdx();
        v = (k >= 0) && !mem_stall && !mHalted;
        r = '{pc: 16'h0, inst: 16'h0, addr: 16'h0, data: 16'h0, rw: 1'b0, mr: 1'b0,
              mw: 1'b0, hlt: 1'b0, wr: 3'b0, age: 0};
        if (v) r = q[k];
        chk("cm_valid",      {31'b0, cm_valid},     {31'b0, v});
        chk("cm_pc",         {16'b0, cm_pc},        {16'b0, r.pc});
        chk("cm_inst",       {16'b0, cm_inst},      {16'b0, r.inst});
        chk("cm_reg_write",  {31'b0, cm_reg_write}, {31'b0, r.rw});
        chk("cm_write_reg",  {29'b0, cm_write_reg}, {29'b0, r.wr});
        chk("cm_write_data", {16'b0, cm_write_data}, v ? {16'b0, wb_write_data} : 32'h0);
        chk("cm_mem_read",   {31'b0, cm_mem_read},  {31'b0, r.mr});
        chk("cm_mem_write",  {31'b0, cm_mem_write}, {31'b0, r.mw});
        chk("cm_mem_addr",   {16'b0, cm_mem_addr},  {16'b0, r.addr});
        chk("cm_mem_data",   {16'b0, cm_mem_data},  {16'b0, r.data});
        chk("cm_halt",       {31'b0, cm_halt},      {31'b0, r.hlt});
        chk("inst_count",    inst_count,            mInst);
        chk("cycle_count",   cycle_count,           mCycle);
        chk("halted",        {31'b0, halted},       {31'b0, mHalted});
    endtask

    task automatic modelEdge();
        int    k;
        bit    wasHalted;
        mrec_t n;
        wasHalted = mHalted;
        k = eligibleIdx();
        if (k >= 0 && !mem_stall && !wasHalted) begin
            mInst++;
            if (q[k].hlt) mHalted = 1'b1;
        end
        if (!wasHalted) mCycle++;
        if (!mem_stall) begin
            if (k >= 0) q.delete(k);
            for (int i = 0; i < q.size(); i++) begin
                if (q[i].age == 1) begin
                    q[i].age = 2;
                end else if (q[i].age == 0) begin
                    q[i].addr = ex_alu_out;
                    q[i].data = ex_store_data;
                    q[i].age  = 1;
                end
            end
            if (id_valid && !stall && !flush && !wasHalted) begin
                n = '{pc: id_pc, inst: id_inst, addr: 16'h0, data: 16'h0, rw: id_reg_write,
                      mr: id_mem_read, mw: id_mem_write, hlt: id_halt, wr: id_write_reg, age: 0};
                q.push_back(n);
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        checkOutputs();
        @(posedge clk);
        modelEdge();
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] pc, input logic st, input logic fl,
                         input logic ms, input logic hl, input logic mw);
        id_valid      = v;
        id_pc         = pc;
        id_inst       = 16'($urandom);
        id_reg_write  = 1'($urandom);
        id_write_reg  = 3'($urandom);
        id_mem_write  = mw;
        id_mem_read   = ~mw & 1'($urandom);
        id_halt       = hl;
        stall         = st;
        flush         = fl;
        mem_stall     = ms;
        wb_write_data = 16'($urandom);
    endtask

    task automatic checkZero(input string tag);
        chk({tag, ".cm_valid"},      {31'b0, cm_valid},      32'h0);
        chk({tag, ".cm_pc"},         {16'b0, cm_pc},         32'h0);
        chk({tag, ".cm_inst"},       {16'b0, cm_inst},       32'h0);
        chk({tag, ".cm_write_data"}, {16'b0, cm_write_data}, 32'h0);
        chk({tag, ".cm_mem_addr"},   {16'b0, cm_mem_addr},   32'h0);
        chk({tag, ".cm_mem_data"},   {16'b0, cm_mem_data},   32'h0);
        chk({tag, ".cm_halt"},       {31'b0, cm_halt},       32'h0);
        chk({tag, ".inst_count"},    inst_count,             32'h0);
        chk({tag, ".cycle_count"},   cycle_count,            32'h0);
        chk({tag, ".halted"},        {31'b0, halted},        32'h0);
    endtask

    // Entered just after a rising edge; reset falls mid-cycle, away from any edge.
    task automatic asyncReset();
        #2 rst = 1'b0;
        #1 checkZero("rst_async");
        q.delete();
        mInst   = 0;
        mCycle  = 0;
        mHalted = 1'b0;
        @(posedge clk);
        #1 checkZero("rst_held");
        #1 rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        ex_alu_out    = 16'h1234;
        ex_store_data = 16'hBEEF;
        wb_write_data = 16'h5A5A;
        q.delete();
        mInst = 0; mCycle = 0; mHalted = 1'b0;
        @(posedge clk);
        #1 checkZero("rst_init");
        asyncReset();

        // In-order stream, 1-edge stall, flush, frozen store, then halt.
        drive(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b1, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b1, 16'h0004, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b1, 16'h0006, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b1, 16'h0006, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b1, 16'h0008, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b1, 16'h000A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); tick();
        drive(1'b1, 16'h000C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0); tick();
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); tick();
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); tick();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 16'h0010 + 16'(2 * i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
        end
        chk("halt_sticky", {31'b0, halted}, 32'h1);
        chk("halt_count",  inst_count,      32'd6);

        // Three records in flight, then reset mid-cycle.
        asyncReset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 16'h0100 + 16'(2 * i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        asyncReset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
        end

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            if (mHalted || $urandom_range(0, 149) == 0) begin
                drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                asyncReset();
            end
            drive($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 7) == 0,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 4) == 0,
                  $urandom_range(0, 59) == 0, $urandom_range(0, 2) == 0);
            ex_alu_out    = 16'($urandom);
            ex_store_data = 16'($urandom);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

endmodule
`default_nettype wire
